// File: rtl/led_gpio_bank.sv
// rtl/led_gpio_bank.sv - memory-mapped LED/GPIO output bank with static, blink and PWM modes
// Optional SET/CLR registers are enabled with macro LED_GPIO_BANK_SETCLR_EN.
module led_gpio_bank #(
  parameter int          NumChannels = 2,
  parameter int          ChanWidth   = 4,
  parameter logic [31:0] BaseAddr    = 32'h0000c000,
  parameter int          TickDiv     = 1000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_i,
  output logic                             gnt_o,
  output logic                             rvalid_o,
  input  logic                             we_i,
  input  logic [3:0]                       be_i,
  input  logic [31:0]                      addr_i,
  input  logic [31:0]                      wdata_i,
  output logic [31:0]                      rdata_o,
  output logic                             err_o,
  output logic [NumChannels*ChanWidth-1:0] led_o
);

  localparam int PW = $clog2(TickDiv);

  logic [NumChannels-1:0][ChanWidth-1:0] out_q, out_d;
  logic [NumChannels-1:0][1:0]           mode_q, mode_d;
  logic [NumChannels-1:0][7:0]           duty_q, duty_d;
  logic [NumChannels-1:0][15:0]          period_q, period_d;
  logic [NumChannels-1:0][15:0]          bcnt_q, bcnt_d;
  logic [NumChannels-1:0]                phase_q, phase_d;
  logic [PW-1:0]                         pres_q, pres_d;
  logic [7:0]                            pwm_q, pwm_d;
  logic [NumChannels*ChanWidth-1:0]      led_q, led_d;
  logic                                  rvalid_q, rvalid_d;
  logic                                  err_q, err_d;
  logic [31:0]                           rdata_q, rdata_d;

  logic        tick;
  logic [31:0] woff;
  logic [31:0] blk;
  logic [1:0]  sub;
  logic        unused_bits;

  assign woff        = (addr_i - BaseAddr) >> 2;
  assign blk         = woff >> 2;
  assign sub         = woff[1:0];
  assign tick        = (pres_q == PW'(TickDiv - 1));
  assign unused_bits = ^{addr_i[1:0], wdata_i[7:0]};

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign led_o    = led_q;

  // Next-state for counters, register file, bus response and LED outputs.
  always_comb begin
    out_d    = out_q;
    mode_d   = mode_q;
    duty_d   = duty_q;
    period_d = period_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    pres_d   = tick ? '0 : pres_q + PW'(1);
    pwm_d    = pwm_q + 8'd1;
    rvalid_d = req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    led_d    = '0;

    // Blink counters advance on the prescaler tick; a CFG write below overrides this.
    for (int c = 0; c < NumChannels; c++) begin
      if (tick && (period_q[c] != 16'd0)) begin
        if (bcnt_q[c] == period_q[c] - 16'd1) begin
          bcnt_d[c]  = '0;
          phase_d[c] = ~phase_q[c];
        end else begin
          bcnt_d[c] = bcnt_q[c] + 16'd1;
        end
      end
    end

    if (req_i) begin
      err_d = 1'b1;
      if (woff == 32'd0) begin
        err_d = 1'b0;
        if (!we_i) rdata_d = {16'b0, 8'(ChanWidth), 8'(NumChannels)};
      end
      for (int c = 0; c < NumChannels; c++) begin
        if (blk == 32'(c + 1)) begin
          case (sub)
            2'd0: begin
              err_d = 1'b0;
              if (we_i) begin
                if (be_i[0]) out_d[c] = wdata_i[ChanWidth-1:0];
              end else begin
                rdata_d = 32'(out_q[c]);
              end
            end
            2'd1: begin
              err_d = 1'b0;
              if (we_i) begin
                if (be_i[0]) mode_d[c] = wdata_i[1:0];
                if (be_i[1]) duty_d[c] = wdata_i[15:8];
                if (be_i[2]) period_d[c][7:0] = wdata_i[23:16];
                if (be_i[3]) period_d[c][15:8] = wdata_i[31:24];
                if (be_i != 4'd0) begin
                  bcnt_d[c]  = '0;
                  phase_d[c] = 1'b1;
                end
              end else begin
                rdata_d = {period_q[c], duty_q[c], 6'b0, mode_q[c]};
              end
            end
`ifdef LED_GPIO_BANK_SETCLR_EN
            2'd2: begin
              err_d = 1'b0;
              if (we_i && be_i[0]) out_d[c] = out_q[c] | wdata_i[ChanWidth-1:0];
            end
            2'd3: begin
              err_d = 1'b0;
              if (we_i && be_i[0]) out_d[c] = out_q[c] & ~wdata_i[ChanWidth-1:0];
            end
`else
            default: err_d = 1'b1;
`endif
          endcase
        end
      end
      if (err_d) rdata_d = '0;
    end

    // Outputs follow the post-write register state so writes show up one cycle later.
    for (int c = 0; c < NumChannels; c++) begin
      case (mode_d[c])
        2'd1:    led_d[c*ChanWidth +: ChanWidth] =
                   ((period_d[c] == 16'd0) || phase_d[c]) ? out_d[c] : '0;
        2'd2:    led_d[c*ChanWidth +: ChanWidth] = (pwm_q < duty_d[c]) ? out_d[c] : '0;
        default: led_d[c*ChanWidth +: ChanWidth] = out_d[c];
      endcase
    end
  end

  // State registers with synchronous reset; blink phase resets to 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      mode_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= '1;
      pres_q   <= '0;
      pwm_q    <= '0;
      led_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      pres_q   <= pres_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_led_gpio_bank.sv
// tb/tb_led_gpio_bank.sv - directed self-checking bench for led_gpio_bank
module tb_led_gpio_bank;

`ifdef LED_GPIO_BANK_SETCLR_EN
  localparam logic [31:0] ExpSet    = 32'h7;
  localparam logic [31:0] ExpClr    = 32'h4;
  localparam logic        ExpSetErr = 1'b0;
`else
  localparam logic [31:0] ExpSet    = 32'h2;
  localparam logic [31:0] ExpClr    = 32'h2;
  localparam logic        ExpSetErr = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [7:0]  led;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] rd;
  logic        e;
  logic [3:0]  samp [0:40];
  int          t1, on_cnt, bad_cnt;
  logic        seg_ok, found;

  led_gpio_bank #(
    .NumChannels(2),
    .ChanWidth  (4),
    .BaseAddr   (32'h0000c000),
    .TickDiv    (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .err_o   (err),
    .led_o   (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] r, output logic er);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = 4'd0;
    check("rvalid", 32'(rvalid), 32'd1);
    r  = rdata;
    er = err;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic pwm_window(output int on, output int bad);
    on = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (led[3:0] == 4'h3) on++;
      else if (led[3:0] != 4'h0) bad++;
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'd0; addr = '0; wdata = '0;
    repeat (3) cycle();
    check("reset_led", 32'(led), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    cycle();
    check("idle_rvalid", 32'(rvalid), 32'h0);

    req = 1'b1; #1;
    check("gnt_comb", 32'(gnt), 32'h1);
    req = 1'b0;
    bus(1'b0, 32'h0000c000, 4'hf, 32'h0, rd, e);
    check("id_rdata", rd, 32'h00000402);
    check("id_err", 32'(e), 32'h0);
    bus(1'b1, 32'h0000c002, 4'hf, 32'hffffffff, rd, e);
    check("id_write_err", 32'(e), 32'h0);
    check("id_write_rdata", rd, 32'h0);

    bus(1'b1, 32'h0000c010, 4'h1, 32'h0000000a, rd, e);
    check("out0_led", 32'(led), 32'h0a);
    check("out0_write_rdata", rd, 32'h0);
    bus(1'b0, 32'h0000c010, 4'hf, 32'h0, rd, e);
    check("out0_readback", rd, 32'h0000000a);
    bus(1'b1, 32'h0000c010, 4'h2, 32'h00000005, rd, e);
    check("out0_be1_led", 32'(led), 32'h0a);
    bus(1'b1, 32'h0000c010, 4'h0, 32'h00000005, rd, e);
    check("out0_be0_err", 32'(e), 32'h0);
    check("out0_be0_led", 32'(led), 32'h0a);

    bus(1'b1, 32'h0000c030, 4'hf, 32'h000000ff, rd, e);
    check("unmapped_wr_err", 32'(e), 32'h1);
    check("unmapped_wr_rdata", rd, 32'h0);
    check("unmapped_led", 32'(led), 32'h0a);
    bus(1'b0, 32'h0000c030, 4'hf, 32'h0, rd, e);
    check("unmapped_rd_err", 32'(e), 32'h1);
    bus(1'b0, 32'h0000c010, 4'hf, 32'h0, rd, e);
    check("unmapped_no_change", rd, 32'h0000000a);

    bus(1'b1, 32'h0000c024, 4'hf, 32'hffffffff, rd, e);
    bus(1'b0, 32'h0000c024, 4'hf, 32'h0, rd, e);
    check("cfg1_readback", rd, 32'hffffff03);
    bus(1'b1, 32'h0000c024, 4'h4, 32'h12345678, rd, e);
    bus(1'b0, 32'h0000c024, 4'hf, 32'h0, rd, e);
    check("cfg1_lane2", rd, 32'hff34ff03);

    bus(1'b1, 32'h0000c010, 4'h1, 32'h00000002, rd, e);
    check("setclr_base_led", 32'(led), 32'h02);
    bus(1'b1, 32'h0000c018, 4'h1, 32'h00000005, rd, e);
    check("set_err", 32'(e), 32'(ExpSetErr));
    check("set_led", 32'(led), ExpSet);
    bus(1'b0, 32'h0000c010, 4'hf, 32'h0, rd, e);
    check("set_out", rd, ExpSet);
    bus(1'b0, 32'h0000c018, 4'hf, 32'h0, rd, e);
    check("set_read_rdata", rd, 32'h0);
    check("set_read_err", 32'(e), 32'(ExpSetErr));
    bus(1'b1, 32'h0000c01c, 4'h1, 32'h00000003, rd, e);
    check("clr_err", 32'(e), 32'(ExpSetErr));
    bus(1'b0, 32'h0000c010, 4'hf, 32'h0, rd, e);
    check("clr_out", rd, ExpClr);

    bus(1'b1, 32'h0000c020, 4'h1, 32'h0000000f, rd, e);
    bus(1'b1, 32'h0000c024, 4'hf, 32'h00020001, rd, e);
    samp[0] = led[7:4];
    check("blink_start", 32'(samp[0]), 32'hf);
    for (int i = 1; i <= 40; i++) begin
      cycle();
      samp[i] = led[7:4];
    end
    t1 = 99;
    for (int i = 40; i >= 1; i--) if (samp[i] != 4'hf) t1 = i;
    check("blink_first_seg", 32'((t1 >= 1) && (t1 <= 8)), 32'h1);
    if (t1 <= 8) begin
      seg_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (samp[t1 + i] != 4'h0) seg_ok = 1'b0;
        if (samp[t1 + 8 + i] != 4'hf) seg_ok = 1'b0;
      end
      if (samp[t1 + 16] != 4'h0) seg_ok = 1'b0;
      check("blink_period8", 32'(seg_ok), 32'h1);
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (led[7:4] == 4'h0) found = 1'b1;
      else cycle();
    end
    check("blink_off_seen", 32'(found), 32'h1);
    bus(1'b1, 32'h0000c024, 4'hf, 32'h00020001, rd, e);
    check("blink_restart", 32'(led[7:4]), 32'hf);
    seg_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (led[7:4] != 4'hf) seg_ok = 1'b0;
    end
    check("blink_restart_hold", 32'(seg_ok), 32'h1);

    bus(1'b1, 32'h0000c010, 4'h1, 32'h00000003, rd, e);
    bus(1'b1, 32'h0000c014, 4'hf, 32'h00004002, rd, e);
    pwm_window(on_cnt, bad_cnt);
    check("pwm64_on", 32'(on_cnt), 32'd64);
    check("pwm64_bad", 32'(bad_cnt), 32'd0);
    bus(1'b1, 32'h0000c014, 4'hf, 32'h00000002, rd, e);
    pwm_window(on_cnt, bad_cnt);
    check("pwm0_on", 32'(on_cnt), 32'd0);
    bus(1'b1, 32'h0000c014, 4'hf, 32'h0000ff02, rd, e);
    pwm_window(on_cnt, bad_cnt);
    check("pwm255_on", 32'(on_cnt), 32'd255);

    req = 1'b1; we = 1'b0; addr = 32'h0000c010; rst = 1'b1;
    cycle();
    req = 1'b0; rst = 1'b0;
    check("midreset_rvalid", 32'(rvalid), 32'h0);
    check("midreset_led", 32'(led), 32'h0);
    bus(1'b0, 32'h0000c010, 4'hf, 32'h0, rd, e);
    check("midreset_out", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/led_gpio_bank.md
Name: led_gpio_bank

Overview:
- Parametrised memory-mapped LED/GPIO output bank on the Ibex data bus. Replaces fixed per-LED store decoders.
- Provides N channels of W bits each, with read-back and per-channel mode: static, blink (tick-based toggle) or PWM dimming.
- Sits beside the SRAM on the core data port. The upstream address decoder asserts req only for this block's window.

Parameters:
- NumChannels, 2, number of output channels; legal range 1..15.
- ChanWidth, 4, bits per channel; legal range 1..8.
- BaseAddr, 32'h0000c000, base of the register window.
- TickDiv, 1000, clock cycles per blink tick; must be at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  bus request.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data.
- err_o  out  1  error, valid with rvalid_o.
- led_o  out  NumChannels*ChanWidth  channel c drives bits [c*ChanWidth +: ChanWidth].

Behaviour:
- Clocking and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: all registers 0; led_o, rvalid_o, rdata_o, err_o all 0; prescaler and PWM counter 0; blink phase 1 for every channel. Reset asserted mid-transaction drops the pending rvalid.
- Handshake:
  - gnt_o = req_i, combinational. One access per cycle.
  - rvalid_o is asserted exactly 1 cycle after each accepted req, for both reads and writes.
  - rdata_o and err_o are registered and valid with rvalid_o. rdata_o is 0 on writes and on errors.
- Decode: addr_i[1:0] ignored. Channel c register base CB = BaseAddr + 0x10*(c+1).
  - BaseAddr+0x0 ID (RO): {16'b0, ChanWidth[7:0], NumChannels[7:0]}. Writes ignored, no err.
  - CB+0x0 OUT (RW): bits [ChanWidth-1:0]; upper bits read 0.
  - CB+0x4 CFG (RW):
    - [1:0] MODE: 0 static, 1 blink, 2 PWM, 3 reserved (behaves as static).
    - [15:8] DUTY.
    - [31:16] PERIOD.
    - All other bits read 0.
  - CB+0x8 and CB+0xC: see Optional Feature.
  - Any other address: err_o=1, no state change.
- Writes apply per byte lane under be_i. be_i=0 is accepted as a no-op, no err.
- Output generation: led_o is registered, and reflects register writes 1 cycle after the write is accepted.
- Prescaler: counts 0..TickDiv-1; tick pulses for 1 cycle when count==TickDiv-1, then wraps to 0.
- Blink (MODE=1):
  - Per-channel counter increments on tick. When counter==PERIOD-1 it wraps to 0 and the phase toggles.
  - Output = OUT when phase=1, else 0.
  - PERIOD=0: output = OUT constantly.
- Any write to CFG clears that channel's blink counter and sets phase=1 in the same cycle.
- PWM (MODE=2):
  - Shared free-running 8-bit counter increments every cycle and wraps 255->0.
  - Output = OUT when counter < DUTY, else 0.
  - DUTY=0 gives always off; DUTY=255 gives off 1 cycle in 256.
- Simultaneous events: a write to OUT in blink or PWM mode takes effect on the next output update without resetting counters. A tick coinciding with a CFG write: the write wins.

Optional Feature:
- Macro: LED_GPIO_BANK_SETCLR_EN.
- Defined:
  - CB+0x8 SET (WO): OUT |= wdata[ChanWidth-1:0].
  - CB+0xC CLR (WO): OUT &= ~wdata[ChanWidth-1:0].
  - Both apply only when be_i[0]=1. Reads of either return 0 with no err.
- Undefined: CB+0x8 and CB+0xC are unmapped, giving err_o=1 and no state change.

Test Plan:
- Reset, then read 0xc000 -> rvalid_o 1 cycle later, rdata_o=0x00000402, err_o=0.
- Write 0xA to 0xc010 with be=0001 -> led_o[3:0]=0xA one cycle later, and read-back gives 0x0000000A. Then write 0x5 with be=0010 -> led_o unchanged.
- TickDiv=4, channel 1: OUT(0xc020)=0xF, CFG(0xc024)=0x00020001 -> led_o[7:4] alternates 0xF/0x0 every 8 cycles, starting with 0xF. Rewriting CFG restarts the sequence at phase 1.
- Channel 0: OUT=0x3, CFG=0x00004002 (DUTY=64, PWM) -> over any 256 consecutive cycles, led_o[3:0]=0x3 for exactly 64 cycles and 0 otherwise.
- Write to 0xc030 with NumChannels=2 -> err_o=1 with rvalid_o, rdata_o=0, and no register or led_o change.
- With LED_GPIO_BANK_SETCLR_EN defined, OUT=0x2: SET 0x5 -> OUT=0x7; CLR 0x3 -> OUT=0x4. Without the macro, the same writes give err_o=1 and OUT stays 0x2.
